dfr_phase_sequencer: RTL

// - Sits directly downstream of the AXI config register block. Consumes its start bit
//   (ctrl[0]) and the num_*_samples / num_steps_per_sample registers, and drives busy

---
 rtl/dfr_pkg.sv | 35 +++
 rtl/dfr_phase_sequencer_if.sv | 36 +++
 rtl/dfr_step_counter.sv | 93 +++++++++
 rtl/dfr_phase_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dfr_pkg.sv
// Shared types for the DFR phase sequencer: FSM states, run phases and the
// layout of the debug status word.
package dfr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_INIT  = 2'd0,
        PH_TRAIN = 2'd1,
        PH_TEST  = 2'd2,
        PH_NONE  = 2'd3
    } phase_t;

    localparam int STAT_IDX_LSB   = 0;
    localparam int STAT_IDX_W     = 24;
    localparam int STAT_PHASE_LSB = 27;
    localparam int STAT_STATE_LSB = 29;

    function automatic logic [31:0] pack_status(input seq_state_t st, input phase_t ph,
                                                input logic [STAT_IDX_W-1:0] idx);
        logic [31:0] s;
        s = '0;
        s[STAT_STATE_LSB +: 3]          = st;
        s[STAT_PHASE_LSB +: 2]          = ph;
        s[STAT_IDX_LSB +: STAT_IDX_W]   = idx;
        return s;
    endfunction

endpackage

// File: rtl/dfr_phase_sequencer_if.sv
// Control/handshake bundle between the config block, the sequencer and the
// reservoir datapath. master = config/datapath side, slave = sequencer.
interface dfr_phase_sequencer_if #(
    parameter int CNT_W = 32
) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_init_samples;
    logic [CNT_W-1:0] num_train_samples;
    logic [CNT_W-1:0] num_test_samples;
    logic [CNT_W-1:0] num_steps_per_sample;
    logic             step_ack;
    logic             busy;
    logic [1:0]       phase;
    logic [CNT_W-1:0] sample_idx;
    logic [CNT_W-1:0] step_idx;
    logic             step_req;
    logic             sample_first;
    logic             sample_last;
    logic             done;
    logic [31:0]      status;

    modport master (
        output start, abort, num_init_samples, num_train_samples, num_test_samples,
               num_steps_per_sample, step_ack,
        input  busy, phase, sample_idx, step_idx, step_req, sample_first, sample_last,
               done, status
    );

    modport slave (
        input  start, abort, num_init_samples, num_train_samples, num_test_samples,
               num_steps_per_sample, step_ack,
        output busy, phase, sample_idx, step_idx, step_req, sample_first, sample_last,
               done, status
    );
endinterface

// File: rtl/dfr_step_counter.sv
// Nested step-within-sample counter. Flags are registered alongside the indices
// so they line up with the indices on the same cycle.
module dfr_step_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [CNT_W-1:0] steps_last_i,
    input  logic [CNT_W-1:0] samples_last_i,
    output logic [CNT_W-1:0] step_idx_o,
    output logic [CNT_W-1:0] sample_idx_o,
    output logic             first_o,
    output logic             last_o,
    output logic             end_o
);
    logic [CNT_W-1:0] step_q, step_d, samp_q, samp_d;
    logic [CNT_W-1:0] steps_last_q, steps_last_d, samples_last_q, samples_last_d;
    logic             first_q, first_d, step_last_q, step_last_d, samp_last_q, samp_last_d;
    logic [CNT_W-1:0] step_inc, samp_inc;

    assign step_inc = step_q + CNT_W'(1);
    assign samp_inc = samp_q + CNT_W'(1);

    always_comb begin
        step_d         = step_q;
        samp_d         = samp_q;
        steps_last_d   = steps_last_q;
        samples_last_d = samples_last_q;
        first_d        = first_q;
        step_last_d    = step_last_q;
        samp_last_d    = samp_last_q;
        if (clr_i) begin
            step_d         = '0;
            samp_d         = '0;
            steps_last_d   = '0;
            samples_last_d = '0;
            first_d        = 1'b0;
            step_last_d    = 1'b0;
            samp_last_d    = 1'b0;
        end else if (load_i) begin
            step_d         = '0;
            samp_d         = '0;
            steps_last_d   = steps_last_i;
            samples_last_d = samples_last_i;
            first_d        = 1'b1;
            step_last_d    = (steps_last_i == '0);
            samp_last_d    = (samples_last_i == '0);
        end else if (adv_i && !(step_last_q && samp_last_q)) begin
            // Equality against count-1 keeps the all-ones count from overflowing.
            if (step_last_q) begin
                step_d      = '0;
                samp_d      = samp_inc;
                first_d     = 1'b1;
                step_last_d = (steps_last_q == '0);
                samp_last_d = (samp_inc == samples_last_q);
            end else begin
                step_d      = step_inc;
                first_d     = 1'b0;
                step_last_d = (step_inc == steps_last_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q         <= '0;
            samp_q         <= '0;
            steps_last_q   <= '0;
            samples_last_q <= '0;
            first_q        <= 1'b0;
            step_last_q    <= 1'b0;
            samp_last_q    <= 1'b0;
        end else begin
            step_q         <= step_d;
            samp_q         <= samp_d;
            steps_last_q   <= steps_last_d;
            samples_last_q <= samples_last_d;
            first_q        <= first_d;
            step_last_q    <= step_last_d;
            samp_last_q    <= samp_last_d;
        end
    end

    assign step_idx_o   = step_q;
    assign sample_idx_o = samp_q;
    assign first_o      = first_q;
    assign last_o       = step_last_q;
    assign end_o        = step_last_q && samp_last_q;

endmodule

// File: rtl/dfr_phase_sequencer.sv
// Runs a DFR job through INIT -> TRAIN -> TEST, issuing one step_req per
// reservoir time step and advancing on step_ack.
module dfr_phase_sequencer
    import dfr_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  rst,
    dfr_phase_sequencer_if.slave  bus
);
    seq_state_t       state_q;
    phase_t           phase_q, nxt_phase;
    logic             busy_q, step_req_q, done_q;
    logic [CNT_W-1:0] ini_q, trn_q, tst_q, steps_q;
    logic [CNT_W-1:0] nxt_cnt, samples_last, steps_last;
    logic [2:0]       first_p;
    logic             abort_any, hs, go_done, cnt_load, cnt_clr, cnt_end;
    logic [CNT_W-1:0] step_idx, sample_idx;
    logic             cnt_first, cnt_last;

    // Earliest phase at or after first_p with a nonzero sample count.
    always_comb begin
        first_p   = (state_q == ST_LOAD) ? 3'd0 : ({1'b0, phase_q} + 3'd1);
        nxt_phase = PH_NONE;
        nxt_cnt   = '0;
        if (first_p <= 3'd2 && tst_q != '0) begin
            nxt_phase = PH_TEST;
            nxt_cnt   = tst_q;
        end
        if (first_p <= 3'd1 && trn_q != '0) begin
            nxt_phase = PH_TRAIN;
            nxt_cnt   = trn_q;
        end
        if (first_p == 3'd0 && ini_q != '0) begin
            nxt_phase = PH_INIT;
            nxt_cnt   = ini_q;
        end
        samples_last = nxt_cnt - CNT_W'(1);
        steps_last   = steps_q - CNT_W'(1);

        abort_any = bus.abort && (state_q != ST_IDLE);
        hs        = (state_q == ST_RUN) && step_req_q && bus.step_ack && !abort_any;
        go_done   = ((state_q == ST_LOAD) && (steps_q == '0 || nxt_phase == PH_NONE))
                 || ((state_q == ST_ADVANCE) && (nxt_phase == PH_NONE));
        cnt_load  = !abort_any && !go_done
                 && (state_q == ST_LOAD || state_q == ST_ADVANCE);
        cnt_clr   = abort_any || go_done;
    end

    always_ff @(posedge S_AXI_ACLK or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_NONE;
            busy_q     <= 1'b0;
            step_req_q <= 1'b0;
            done_q     <= 1'b0;
            ini_q      <= '0;
            trn_q      <= '0;
            tst_q      <= '0;
            steps_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_any) begin
                state_q    <= ST_IDLE;
                phase_q    <= PH_NONE;
                busy_q     <= 1'b0;
                step_req_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state_q <= ST_LOAD;
                            busy_q  <= 1'b1;
                            ini_q   <= bus.num_init_samples;
                            trn_q   <= bus.num_train_samples;
                            tst_q   <= bus.num_test_samples;
                            steps_q <= bus.num_steps_per_sample;
                        end
                    end
                    ST_LOAD, ST_ADVANCE: begin
                        if (go_done) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            phase_q    <= PH_NONE;
                            step_req_q <= 1'b0;
                        end else begin
                            state_q    <= ST_RUN;
                            phase_q    <= nxt_phase;
                            step_req_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (hs && cnt_end) begin
                            state_q    <= ST_ADVANCE;
                            step_req_q <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        phase_q    <= PH_NONE;
                        busy_q     <= 1'b0;
                        step_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    dfr_step_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk            (S_AXI_ACLK),
        .rst            (rst),
        .clr_i          (cnt_clr),
        .load_i         (cnt_load),
        .adv_i          (hs),
        .steps_last_i   (steps_last),
        .samples_last_i (samples_last),
        .step_idx_o     (step_idx),
        .sample_idx_o   (sample_idx),
        .first_o        (cnt_first),
        .last_o         (cnt_last),
        .end_o          (cnt_end)
    );

    assign bus.busy         = busy_q;
    assign bus.phase        = phase_q;
    assign bus.sample_idx   = sample_idx;
    assign bus.step_idx     = step_idx;
    assign bus.step_req     = step_req_q;
    assign bus.sample_first = cnt_first;
    assign bus.sample_last  = cnt_last;
    assign bus.done         = done_q;
    assign bus.status       = pack_status(state_q, phase_q, sample_idx[STAT_IDX_W-1:0]);

endmodule
